// File: rtl/hex_line_to_dec_if.sv
// Byte handshakes between the UART receiver, the hex-line converter and the UART transmitter.
interface hex_line_to_dec_if;
  logic       input_valid;
  logic [7:0] input_data;
  logic       output_busy;
  logic       output_en;
  logic [7:0] output_data;

  modport master (
    output input_valid, input_data, output_busy,
    input  output_en, output_data
  );

  modport slave (
    input  input_valid, input_data, output_busy,
    output output_en, output_data
  );
endinterface

// File: rtl/hex_line_to_dec.sv
// Collects a line of ASCII hex digits, converts it to BCD with double dabble and
// emits the decimal string without leading zeros, followed by '\n'.
module hex_line_to_dec #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = 10
) (
  input  logic             clk,
  input  logic             rst,
  hex_line_to_dec_if.slave bus
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = $clog2(DIGITS);

  typedef enum logic [1:0] {ACCUM, CONVERT, SEND} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [BW-1:0]    bcd_q,   bcd_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    ptr_q,   ptr_d;
  logic             nl_q,    nl_d;

  logic             is_hex;
  logic [3:0]       nib;
  logic [BW-1:0]    bcd_adj;
  logic [BW-1:0]    bcd_shift;
  logic [WIDTH-1:0] value_shift;
  logic [PW-1:0]    lead;
  logic [3:0]       cur_digit;

  always_comb begin
    is_hex = 1'b0;
    nib    = '0;
    if (bus.input_data >= 8'h30 && bus.input_data <= 8'h39) begin
      is_hex = 1'b1;
      nib    = 4'(bus.input_data - 8'h30);
    end else if (bus.input_data >= 8'h61 && bus.input_data <= 8'h66) begin
      is_hex = 1'b1;
      nib    = 4'(bus.input_data - 8'h57);
    end else if (bus.input_data >= 8'h41 && bus.input_data <= 8'h46) begin
      is_hex = 1'b1;
      nib    = 4'(bus.input_data - 8'h37);
    end
  end

  // One double-dabble step: correct digits >= 5, then shift {bcd, value} left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    {bcd_shift, value_shift} = {bcd_adj[BW-2:0], value_q, 1'b0};
  end

  // Leading-zero skip is resolved on the final convert step, so SEND starts on
  // the most significant non-zero digit (digit 0 when the whole value is zero).
  always_comb begin
    lead = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_shift[4*i +: 4] != 4'd0)
        lead = PW'(i);
    end
  end

  assign cur_digit = bcd_q[4*ptr_q +: 4];

  always_comb begin
    state_d         = state_q;
    value_d         = value_q;
    bcd_d           = bcd_q;
    count_d         = count_q;
    ptr_d           = ptr_q;
    nl_d            = nl_q;
    bus.output_en   = 1'b0;
    bus.output_data = '0;

    unique case (state_q)
      ACCUM: begin
        if (bus.input_valid) begin
          if (is_hex) begin
            value_d = {value_q[WIDTH-5:0], nib};
          end else if (bus.input_data == 8'h0A) begin
            count_d = CW'(WIDTH);
            bcd_d   = '0;
            state_d = CONVERT;
          end
        end
      end

      CONVERT: begin
        bcd_d   = bcd_shift;
        value_d = value_shift;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = SEND;
          ptr_d   = lead;
          nl_d    = 1'b0;
        end
      end

      SEND: begin
        if (!bus.output_busy) begin
          bus.output_en   = 1'b1;
          bus.output_data = nl_q ? 8'h0A : {4'h3, cur_digit};
          if (nl_q) begin
            state_d = ACCUM;
            value_d = '0;
            nl_d    = 1'b0;
          end else if (ptr_q == '0) begin
            nl_d = 1'b1;
          end else begin
            ptr_d = ptr_q - PW'(1);
          end
        end
      end

      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      value_q <= '0;
      bcd_q   <= '0;
      count_q <= '0;
      ptr_q   <= '0;
      nl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      bcd_q   <= bcd_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      nl_q    <= nl_d;
    end
  end

endmodule

// File: tb/tb_hex_line_to_dec.sv
// Directed bench for hex_line_to_dec: hex lines in, decimal lines out.
module tb_hex_line_to_dec;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned DIGITS = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hex_line_to_dec_if bus ();

  hex_line_to_dec #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int last_edge = 0;
  byte unsigned rxq[$];
  int emit_edge[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input string got, input string exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got '%s' expected '%s'", tag, got, exp);
    end
  endtask

  // Receiver model: a byte is taken at the edge that follows a cycle with output_en=1.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.output_en) begin
        if (bus.output_busy)
          check("en_while_busy", "1", "0");
        rxq.push_back(bus.output_data);
        emit_edge.push_back(cyc + 1);
      end else if (bus.output_data != 8'h00) begin
        check("data_when_idle", $sformatf("%02h", bus.output_data), "00");
      end
    end
  end

  function automatic string drain();
    string s = "";
    foreach (rxq[i]) begin
      if (rxq[i] == 8'h0A) s = {s, "\\n"};
      else                 s = $sformatf("%s%c", s, rxq[i]);
    end
    rxq.delete();
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input byte unsigned b);
    bus.input_valid = 1'b1;
    bus.input_data  = b;
    tick();
    last_edge       = cyc;
    bus.input_valid = 1'b0;
    bus.input_data  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  function automatic bit line_done();
    return (rxq.size() > 0) && (rxq[rxq.size()-1] == 8'h0A);
  endfunction

  task automatic wait_line(input string tag, input int budget, output string got);
    int n = 0;
    while (!line_done() && n < budget) begin
      tick();
      n++;
    end
    if (!line_done()) check({tag, "_timeout"}, "expired", "line");
    got = drain();
  endtask

  task automatic run_line(input string tag, input string in, input string exp);
    string got;
    send_str(in);
    wait_line(tag, 200, got);
    check(tag, got, exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got 'timeout' expected 'finish'");
    $fatal(1, "watchdog");
  end

  initial begin
    string got;
    int nl, n;

    rst             = 1'b1;
    bus.input_valid = 1'b0;
    bus.input_data  = 8'h00;
    bus.output_busy = 1'b0;
    repeat (3) tick();
    check("rst_en",   $sformatf("%0d", bus.output_en), "0");
    check("rst_data", $sformatf("%02h", bus.output_data), "00");
    rst = 1'b0;
    tick();

    // "ff\n": latency and back-to-back bytes
    emit_edge.delete();
    send_str("ff\n");
    nl = last_edge;
    wait_line("ff", 200, got);
    check("ff_line", got, "255\\n");
    check("ff_count", $sformatf("%0d", emit_edge.size()), "4");
    if (emit_edge.size() >= 4) begin
      check("ff_latency", $sformatf("%0d", emit_edge[0] - nl), $sformatf("%0d", WIDTH + 1));
      check("ff_span",    $sformatf("%0d", emit_edge[3] - emit_edge[0]), "3");
    end

    run_line("zero",     "\n",          "0\\n");
    run_line("all_ones", "FFFFFFFF\n",  "4294967295\\n");
    run_line("overflow", "123456789\n", "591751049\\n");
    run_line("ignored",  "1x2\r\n",     "18\\n");

    // Backpressure: busy for 5 SEND cycles, then alternating
    bus.output_busy = 1'b1;
    send_str("a\n");
    repeat (WIDTH) tick();
    repeat (5) tick();
    check("busy_hold", $sformatf("%0d", rxq.size()), "0");
    n = 0;
    while (!line_done() && n < 60) begin
      bus.output_busy = ~bus.output_busy;
      tick();
      n++;
    end
    bus.output_busy = 1'b0;
    got = drain();
    check("busy_line", got, "10\\n");

    // Bytes arriving during CONVERT are dropped
    send_str("7\n");
    send_str("3\n");
    wait_line("inject", 200, got);
    check("inject_line", got, "7\\n");
    repeat (50) tick();
    check("inject_quiet", $sformatf("%0d", rxq.size()), "0");
    run_line("after_inject", "4\n", "4\\n");

    // Reset mid-send abandons the line
    send_str("ff\n");
    n = 0;
    while (rxq.size() == 0 && n < 100) begin
      tick();
      n++;
    end
    got = (rxq.size() > 0) ? $sformatf("%c", rxq[0]) : "";
    check("rst_first_byte", got, "2");
    rst = 1'b1;
    tick();
    check("rst_mid_en", $sformatf("%0d", bus.output_en), "0");
    rst = 1'b0;
    rxq.delete();
    repeat (60) tick();
    check("rst_quiet", $sformatf("%0d", rxq.size()), "0");
    run_line("after_rst", "1\n", "1\\n");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hex_line_to_dec.md
Name: hex_line_to_dec

Overview:
- Line-oriented byte-stream converter: the inverse of our decimal-in/hex-out puzzle stage.
- Accepts ASCII hexadecimal digits terminated by '\n', converts the accumulated value to binary-coded decimal, and emits the decimal ASCII string followed by '\n'.
- Sits between the UART receiver (input_valid/input_data) and the UART transmitter (output_busy/output_en/output_data), using the same byte handshakes.

Parameters:
- WIDTH, 32, bit width of the accumulated value.
- DIGITS, 10, number of BCD digits. Must satisfy 10^DIGITS >= 2^WIDTH.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- input_valid  input  1  one-cycle strobe: input_data holds a received byte.
- input_data  input  8  received byte.
- output_busy  input  1  transmitter cannot accept a byte this cycle.
- output_en  output  1  one-cycle strobe: output_data is sent this cycle.
- output_data  output  8  byte to send.

Behaviour:
- Reset (rst high at a clock edge, in any state, including mid-convert or mid-send):
  - state=ACCUM, value=0, BCD register=0, counters=0.
  - output_en=0, output_data=0.
  - Any partially sent line is abandoned.
- States: ACCUM -> CONVERT -> SEND -> ACCUM.
- ACCUM (accepts a byte only when input_valid=1):
  - '0'-'9', 'a'-'f', 'A'-'F': value <= {value[WIDTH-5:0], nibble}. More than WIDTH/4 digits keep the low WIDTH bits.
  - '\n': load the shift count WIDTH, clear BCD, go to CONVERT. value is not modified.
  - Any other byte (including '\r'): ignored, no state change.
- CONVERT (double dabble, one step per cycle):
  - Each cycle, add 3 to every BCD digit >= 5, then shift {bcd, value} left by 1 and decrement the count.
  - After exactly WIDTH steps, go to SEND.
  - Latency: if '\n' is accepted at edge T, the first SEND cycle is T+WIDTH+1.
  - All input bytes arriving in CONVERT or SEND are dropped; there is no buffering.
- SEND:
  - Leading-zero digits are skipped without spending any cycle on them. A value of 0 emits the single digit "0".
  - Then emit the remaining digits MS-first, then '\n'.
  - In a cycle with output_busy=0: output_en=1, output_data = the current byte, and the pointer advances at the edge.
  - In a cycle with output_busy=1: output_en=0, and the pointer and data hold.
  - On the edge that emits '\n': value <= 0, state <= ACCUM.
- output_data is 0 whenever output_en=0.
- output_en is never high outside SEND.
- output_en and output_data are combinational from state and output_busy; there are no other outputs.
- Arithmetic is unsigned. No error reporting: overflow truncates silently.

Test Plan:
- "ff\n", output_busy=0 -> bytes "2","5","5","\n" on four consecutive cycles; the first arrives WIDTH+1 cycles after the '\n' edge.
- "\n" alone -> "0\n". "FFFFFFFF\n" -> "4294967295\n" (all 10 digits, uppercase hex accepted).
- "123456789\n" (9 digits, overflow) -> low 32 bits 0x23456789 -> "591751049\n". "1x2\r\n" -> 'x' and '\r' ignored -> "18\n".
- "a\n", with output_busy held high for 5 cycles after SEND entry, then toggled 1/0 every cycle -> output_en only when busy=0; exactly "10\n" sent with no duplicated or lost byte.
- "7\n", then "3\n" injected during CONVERT -> only "7\n" emitted. A following "4\n" -> "4\n", proving value was cleared and the dropped bytes had no effect.
- "ff\n", with rst pulsed after the first output byte -> output_en=0 from the reset edge onward, no further bytes. A subsequent "1\n" -> "1\n".
